// File: rtl/nf_fetch_pkg.sv
// Shared types and constants for the nf_instr_fetch sequencer.
package nf_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] NF_NOP         = 32'h0000_0013;
    localparam int          NF_TIMEOUT_DEF = 255;

endpackage

// File: rtl/nf_instr_fetch.sv
// Fetch sequencer: issues one req/ack read per CPU instruction and strobes cpu_en once per fetched word.
// state | meaning
// IDLE  | waiting for run; latches cpu_addr and raises mem_req on the way out
// REQ   | bus request outstanding; timeout counter running
// EXEC  | cpu_en high for one cycle, instruction retired
// ERR   | bus hang detected; sticky until resetn
module nf_instr_fetch
    import nf_fetch_pkg::*;
#(
    parameter int TIMEOUT = NF_TIMEOUT_DEF,
    parameter int TMR_W   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_instr,
    output logic        cpu_en,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_err,
    output logic [31:0] instr_cnt
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] timer;
    logic             ack_hit;
    logic             tmo_hit;

    // Ack takes priority over a timeout landing on the same edge.
    assign ack_hit = (state == ST_REQ) && mem_ack;
    assign tmo_hit = (state == ST_REQ) && !mem_ack && (TIMEOUT != 0) && (timer == TMR_LAST);

    assign cpu_en = (state == ST_EXEC);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (run)          state_nxt = ST_REQ;
            ST_REQ: begin
                if (ack_hit)           state_nxt = ST_EXEC;
                else if (tmo_hit)      state_nxt = ST_ERR;
            end
            ST_EXEC:                   state_nxt = ST_IDLE;
            ST_ERR:                    state_nxt = ST_ERR;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_req   <= 1'b0;
            mem_addr  <= 32'h0;
            cpu_instr <= NF_NOP;
            bus_err   <= 1'b0;
            instr_cnt <= 32'h0;
            timer     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        mem_addr <= cpu_addr;
                        mem_req  <= 1'b1;
                        timer    <= '0;
                    end
                end
                ST_REQ: begin
                    if (ack_hit) begin
                        cpu_instr <= mem_rdata;
                        mem_req   <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                        if (tmo_hit) begin
                            mem_req <= 1'b0;
                            bus_err <= 1'b1;
                        end
                    end
                end
                ST_EXEC: instr_cnt <= instr_cnt + 32'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nf_instr_fetch.sv
// Directed self-checking bench for nf_instr_fetch (TIMEOUT=16).
module tb_nf_instr_fetch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        run;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_instr;
    logic        cpu_en;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic [31:0] instr_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_instr;
    logic [31:0] exp_cnt;

    nf_instr_fetch #(.TIMEOUT(16), .TMR_W(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .run       (run),
        .cpu_addr  (cpu_addr),
        .cpu_instr (cpu_instr),
        .cpu_en    (cpu_en),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the DUT in IDLE; ends at a negedge back in IDLE.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
        cpu_addr = addr;
        run      = 1'b1;
        @(negedge clk);
        chk("req_rise", {31'b0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, addr);
        chk("req_no_en", {31'b0, cpu_en}, 32'd0);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("wait_req", {31'b0, mem_req}, 32'd1);
            chk("wait_addr", mem_addr, addr);
            chk("wait_no_en", {31'b0, cpu_en}, 32'd0);
            chk("wait_instr_hold", cpu_instr, exp_instr);
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        exp_instr = data;
        chk("exec_en", {31'b0, cpu_en}, 32'd1);
        chk("exec_instr", cpu_instr, exp_instr);
        chk("exec_req_low", {31'b0, mem_req}, 32'd0);
        chk("exec_cnt_before", instr_cnt, exp_cnt);
        @(negedge clk);
        exp_cnt = exp_cnt + 32'd1;
        chk("post_en_low", {31'b0, cpu_en}, 32'd0);
        chk("post_cnt", instr_cnt, exp_cnt);
        chk("post_instr_hold", cpu_instr, exp_instr);
    endtask

    initial begin
        resetn    = 1'b0;
        run       = 1'b0;
        cpu_addr  = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        exp_instr = 32'h0000_0013;
        exp_cnt   = 32'h0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_en", {31'b0, cpu_en}, 32'd0);
        chk("rst_instr", cpu_instr, 32'h0000_0013);
        chk("rst_err", {31'b0, bus_err}, 32'd0);
        chk("rst_cnt", instr_cnt, 32'h0);
        resetn = 1'b1;

        // Stays idle without run, even with a stray ack
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_1111;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_req", {31'b0, mem_req}, 32'd0);
        chk("idle_en", {31'b0, cpu_en}, 32'd0);
        chk("idle_instr", cpu_instr, 32'h0000_0013);

        // Basic fetch and back-to-back 3-cycle period
        do_fetch(32'h0000_0000, 32'h0050_0093, 0);
        do_fetch(32'h0000_0004, 32'h0010_8113, 0);

        // Four wait states, then ack exactly on the timeout boundary
        do_fetch(32'h0000_0008, 32'h0020_0193, 4);
        do_fetch(32'h0000_000C, 32'h0030_0213, 15);
        chk("boundary_no_err", {31'b0, bus_err}, 32'd0);

        // Run dropped during REQ: fetch completes, then idle
        cpu_addr = 32'h0000_0100;
        run      = 1'b1;
        @(negedge clk);
        chk("gate_req", {31'b0, mem_req}, 32'd1);
        run = 1'b0;
        @(negedge clk);
        chk("gate_req_hold", {31'b0, mem_req}, 32'd1);
        chk("gate_addr", mem_addr, 32'h0000_0100);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0040_0293;
        @(negedge clk);
        mem_ack = 1'b0;
        exp_instr = 32'h0040_0293;
        chk("gate_en", {31'b0, cpu_en}, 32'd1);
        chk("gate_instr", cpu_instr, exp_instr);
        exp_cnt = exp_cnt + 32'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("gate_idle_req", {31'b0, mem_req}, 32'd0);
            chk("gate_idle_en", {31'b0, cpu_en}, 32'd0);
        end
        chk("gate_cnt", instr_cnt, exp_cnt);
        do_fetch(32'h0000_0200, 32'h0050_0313, 1);

        // Counter wrap
        force dut.instr_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.instr_cnt;
        chk("wrap_preload", instr_cnt, 32'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        do_fetch(32'h0000_0204, 32'h0060_0393, 0);
        chk("wrap_zero", instr_cnt, 32'h0);

        // Asynchronous reset while a request is outstanding
        cpu_addr = 32'h0000_0300;
        run      = 1'b1;
        @(negedge clk);
        chk("areq_req", {31'b0, mem_req}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_req", {31'b0, mem_req}, 32'd0);
        chk("arst_instr", cpu_instr, 32'h0000_0013);
        chk("arst_cnt", instr_cnt, 32'h0);
        chk("arst_en", {31'b0, cpu_en}, 32'd0);
        chk("arst_addr", mem_addr, 32'h0);
        run = 1'b0;
        @(negedge clk);
        resetn    = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_instr", cpu_instr, 32'h0000_0013);
        chk("late_ack_req", {31'b0, mem_req}, 32'd0);
        chk("late_ack_en", {31'b0, cpu_en}, 32'd0);
        chk("late_ack_cnt", instr_cnt, 32'h0);

        // Timeout: 16 REQ cycles without ack
        exp_instr = 32'h0000_0013;
        cpu_addr  = 32'h0000_0400;
        run       = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("tmo_req_hold", {31'b0, mem_req}, 32'd1);
            chk("tmo_no_err", {31'b0, bus_err}, 32'd0);
        end
        @(negedge clk);
        chk("tmo_err", {31'b0, bus_err}, 32'd1);
        chk("tmo_req_low", {31'b0, mem_req}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("err_en", {31'b0, cpu_en}, 32'd0);
            chk("err_req", {31'b0, mem_req}, 32'd0);
            chk("err_sticky", {31'b0, bus_err}, 32'd1);
        end
        mem_ack = 1'b0;
        chk("err_instr", cpu_instr, exp_instr);
        chk("err_cnt", instr_cnt, 32'h0);
        resetn = 1'b0;
        #1;
        chk("err_clear", {31'b0, bus_err}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run    = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
